// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr_i, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] rot_req;
    logic [IDX_W-1:0]   cand [NUM_REQ];

    // cand[gi] is the requester gi positions after the pointer, modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [IDX_W:0] sum;
        assign sum         = {1'b0, ptr_i} + (IDX_W+1)'(gi);
        assign cand[gi]    = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                             IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
        assign rot_req[gi] = req_i[cand[gi]];
    end

    always_comb begin
        idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                idx_o = cand[k];
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional source-ID header byte per packet: define UART_TX_ARBITER_ID_HEADER_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE   = DATA_WIDTH'(8'hF0)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [IDX_W-1:0]       next_ptr;
    logic [DATA_WIDTH-1:0]  lane_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (s_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        m_valid  = 1'b0;
        m_data   = '0;
        s_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
`ifdef UART_TX_ARBITER_ID_HEADER_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end
            end
`ifdef UART_TX_ARBITER_ID_HEADER_EN
            HDR: begin
                m_valid = 1'b1;
                m_data  = HDR_BASE | DATA_WIDTH'(grant_q);
                if (m_ready) begin
                    state_d = SEND;
                end
            end
`endif
            SEND: begin
                // The granted lane is wired straight through; the grant holds across valid gaps.
                m_data           = lane_data[grant_q];
                m_valid          = s_valid[grant_q];
                s_ready[grant_q] = m_ready;
                if (s_valid[grant_q] && m_ready && s_last[grant_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

`ifndef UART_TX_ARBITER_ID_HEADER_EN
    logic unused_hdr_base;
    assign unused_hdr_base = ^HDR_BASE;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Grants one requester at a time and holds the grant for a whole packet, so bytes from different requesters never interleave on the line.
- Sits between the requesters (debug console, status reporter, etc.) and the uart_tx data/valid/ready interface.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH.
- HDR_BASE, 8'hF0, header byte base value; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- s_data  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_valid  in  NUM_REQ  per-requester byte valid
- s_last  in  NUM_REQ  per-requester last-byte-of-packet flag, qualified by s_valid
- s_ready  out  NUM_REQ  per-requester accept
- m_data  out  DATA_WIDTH  byte to uart_tx data
- m_valid  out  1  to uart_tx valid
- m_ready  in  1  from uart_tx ready
- grant_id  out  $clog2(NUM_REQ)  index of the currently granted requester
- busy  out  1  high while a packet is in progress (state other than IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active high. All state is cleared on rst assertion, independent of clk.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, m_valid=0, m_data=0, s_ready=0, busy=0.
- Handshake rules:
  - Upstream transfer on requester i: s_valid[i] & s_ready[i].
  - Downstream transfer: m_valid & m_ready in the same cycle.
  - A requester must hold s_valid, s_data and s_last stable until its transfer. Behaviour is undefined if it drops them.
- FSM, 2 states (3 with the optional feature):
  - IDLE:
    - m_valid=0, s_ready=0.
    - If any s_valid is high, pick the first set bit searching from rr_ptr upward with wrap-around. Register it into grant_id. Next state SEND.
    - Latency: 1 cycle from s_valid to grant.
  - SEND:
    - Combinational pass-through: m_data=s_data[grant_id], m_valid=s_valid[grant_id], s_ready[grant_id]=m_ready. All other s_ready bits stay 0.
    - On a downstream transfer with s_last[grant_id]=1: rr_ptr <= (grant_id+1) mod NUM_REQ, next state IDLE.
    - On a transfer without last: stay in SEND.
- Arbitration boundary conditions:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - If only the just-served requester is pending, it is re-granted.
  - Requests arriving during SEND wait; they do not preempt.
  - Simultaneous requests resolve by round-robin order.
  - A packet of one byte (s_last set on the first byte) is legal.
- Inter-packet gap: one IDLE cycle minimum between packets. This gap is hidden by the uart_tx frame time.
- Zero-length gaps inside a packet (s_valid low while granted) are legal. The grant is held.
- Reset mid-packet: the grant is dropped and the FSM returns to IDLE. The downstream byte already accepted by uart_tx still completes on the line.
- uart_tx ready drops the cycle after acceptance. The arbiter keeps no per-byte state beyond that, so no extra flow control is needed.

Optional Feature:
- Macro UART_TX_ARBITER_ID_HEADER_EN.
- When defined: a HDR state is inserted between IDLE and SEND.
  - In HDR: m_valid=1, m_data=HDR_BASE | grant_id (zero-extended), s_ready=0.
  - On a downstream transfer, go to SEND.
  - Each packet on the line is therefore prefixed by one header byte identifying its source.
- When undefined: there is no HDR state, and IDLE goes directly to SEND.

Decomposition:
- Package uart_arb_pkg holds:
  - the state typedef enum {IDLE, HDR, SEND};
  - a function for grant-index width ($clog2 with minimum 1).
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs: request vector and rr_ptr. Outputs: index and any-request flag. It is reusable by other arbiters.

Test Plan:
1. Reset then idle: rst pulse with all s_valid=0 -> m_valid=0, s_ready=0, busy=0, grant_id=0 for 20 cycles.
2. Single requester:
   - Stimulus: req 2 sends bytes 0x41,0x42,0x43 with last on 0x43, into a uart_tx model (PULSE_WIDTH=4).
   - Required: grant_id=2; three transfers in order; then busy=0 and rr_ptr=3.
3. Contention:
   - Stimulus: reqs 0,1,3 each present a 2-byte packet in the same cycle.
   - Required: packet order 0,1,3 with no interleaved bytes. A second round starting from rr_ptr=0 then gives order 0,1,3 again.
4. Wrap and re-grant:
   - Stimulus: rr_ptr=3 with only req 3 pending.
   - Required: req 3 granted. With reqs 0 and 3 pending after it, req 0 is granted next.
5. Reset mid-packet: assert rst during byte 2 of a 4-byte packet -> outputs at reset values immediately; the next packet starts cleanly from rr_ptr=0.
6. With UART_TX_ARBITER_ID_HEADER_EN defined: req 1 sends the single byte 0x55 with last -> line carries 0xF1 then 0x55.
